// File: rtl/execution_controller.sv
// Run/debug sequencer: debounces the board buttons and drives a registered,
// glitch-free processor clock-enable and reset from a six-state FSM.
module execution_controller #(
   parameter int N               = 24,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RST_CYCLES      = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pwr,
   input  logic         dbg,
   input  logic         stp,
   input  logic         halt_req,
   output logic         proc_en,
   output logic         proc_rst,
   output logic [2:0]   state,
   output logic [N-1:0] cycle_count,
   output logic         done
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_RESET = 3'd1,
      S_RUN   = 3'd2,
      S_DEBUG = 3'd3,
      S_STEP  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   // Button vectors are ordered {stp, dbg, pwr}.
   logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [2:0]    lvl_q, lvl_d, press_q, press_d;
   logic [DW-1:0] db_cnt_q [3];
   logic [DW-1:0] db_cnt_d [3];
   state_t        state_q, state_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic          proc_en_q, proc_en_d, proc_rst_q, proc_rst_d, done_q, done_d;
   logic [N-1:0]  count_q, count_d;
   logic          pwr_ev, dbg_ev, stp_ev;

   always_comb begin
      sync1_d = {stp, dbg, pwr};
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      press_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               lvl_d[i]   = sync2_q[i];
               press_d[i] = ~sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign pwr_ev = press_q[0];
   assign dbg_ev = press_q[1];
   assign stp_ev = press_q[2];

   // Nested if/else chains encode the pwr > halt_req > dbg > stp priority.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = '0;
      case (state_q)
         S_OFF: if (pwr_ev) state_d = S_RESET;
         S_RESET: begin
            if (pwr_ev)                      state_d = S_RESET;
            else if (rst_cnt_q == RST_LAST)  state_d = S_RUN;
            else                             rst_cnt_d = rst_cnt_q + 1'b1;
         end
         S_RUN: begin
            if (pwr_ev)        state_d = S_RESET;
            else if (halt_req) state_d = S_HALT;
            else if (dbg_ev)   state_d = S_DEBUG;
         end
         S_DEBUG: begin
            if (pwr_ev)        state_d = S_RESET;
            else if (dbg_ev)   state_d = S_RUN;
            else if (stp_ev)   state_d = S_STEP;
         end
         S_STEP:  state_d = halt_req ? S_HALT : S_DEBUG;
         S_HALT:  if (pwr_ev) state_d = S_RESET;
         default: state_d = S_OFF;
      endcase

      proc_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
      proc_rst_d = (state_d == S_OFF) || (state_d == S_RESET);
      done_d     = (state_d == S_HALT);

      count_d = count_q;
      if (state_d == S_RESET)
         count_d = '0;
      else if (proc_en_q && (count_q != {N{1'b1}}))
         count_d = count_q + 1'b1;
   end

   // Synchronizers and debounced levels idle at 1 (released) so reset exit
   // never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= 3'b111;
         sync2_q    <= 3'b111;
         lvl_q      <= 3'b111;
         press_q    <= 3'b000;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
         state_q    <= S_OFF;
         rst_cnt_q  <= '0;
         proc_en_q  <= 1'b0;
         proc_rst_q <= 1'b1;
         done_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         lvl_q      <= lvl_d;
         press_q    <= press_d;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         proc_en_q  <= proc_en_d;
         proc_rst_q <= proc_rst_d;
         done_q     <= done_d;
         count_q    <= count_d;
      end
   end

   assign proc_en     = proc_en_q;
   assign proc_rst    = proc_rst_q;
   assign done        = done_q;
   assign state       = state_q;
   assign cycle_count = count_q;

endmodule
